// File: rtl/battle_pkg.sv
// Shared grid constants, cell coordinate types and the
// random cell generator state encoding.
package battle_pkg;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;

  typedef logic [4:0] cell_x_t;
  typedef logic [3:0] cell_y_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    QUERY,
    CHECK,
    EMIT
  } rcg_state_t;

endpackage

// File: rtl/random_cell_gen_if.sv
// Occupancy read port and chosen-cell result bundle of the
// random cell generator.
interface random_cell_gen_if;
  import battle_pkg::*;

  logic    cell_rd_req;
  cell_x_t cell_rd_x;
  cell_y_t cell_rd_y;
  logic    cell_rd_occ;
  logic    randomRise;
  cell_x_t randomX;
  cell_y_t randomY;

  modport master (
    output cell_rd_req,
    output cell_rd_x,
    output cell_rd_y,
    input  cell_rd_occ,
    output randomRise,
    output randomX,
    output randomY
  );

  modport slave (
    input  cell_rd_req,
    input  cell_rd_x,
    input  cell_rd_y,
    output cell_rd_occ,
    input  randomRise,
    input  randomX,
    input  randomY
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR,
// polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/random_cell_gen.sv
// Picks a pseudo-random free maze cell and pulses randomRise.
// Define RANDOM_CELL_EXCLUDE_BORDER_EN to keep picks off the outer ring.
module random_cell_gen
  import battle_pkg::*;
#(
  parameter int          COLS         = GRID_COLS,
  parameter int          ROWS         = GRID_ROWS,
  parameter int          SPAWN_PERIOD = 10,
  parameter int          MAX_TRIES    = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               one_sec,
  input  logic               newRandom,
  random_cell_gen_if.master  bus,
  output logic               busy
);

  localparam int PW = $clog2(SPAWN_PERIOD + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [PW-1:0] PER  = PW'(SPAWN_PERIOD);
  localparam logic [TW-1:0] TMAX = TW'(MAX_TRIES);
  localparam logic [5:0]    XLIM = 6'(COLS);
  localparam logic [4:0]    YLIM = 5'(ROWS);

  rcg_state_t    state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] tries_q, tries_d;
  cell_x_t       cand_x_q, cand_x_d;
  cell_y_t       cand_y_q, cand_y_d;
  cell_x_t       rx_q, rx_d;
  cell_y_t       ry_q, ry_d;

  logic [15:0] lfsr;
  cell_x_t     draw_x;
  cell_y_t     draw_y;
  logic        in_grid;
  logic        edge_hit;
  logic        cand_ok;
  logic        tick_hit;
  logic        lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .resetN  (resetN),
    .state_o (lfsr)
  );

  assign draw_x      = lfsr[4:0];
  assign draw_y      = lfsr[11:8];
  assign lfsr_unused = ^{lfsr[15:12], lfsr[7:5]};

  assign in_grid = ({1'b0, draw_x} < XLIM) &&
                   ({1'b0, draw_y} < YLIM);

`ifdef RANDOM_CELL_EXCLUDE_BORDER_EN
  assign edge_hit = (draw_x == '0) ||
                    ({1'b0, draw_x} == XLIM - 6'd1) ||
                    (draw_y == '0) ||
                    ({1'b0, draw_y} == YLIM - 5'd1);
`else
  assign edge_hit = 1'b0;
`endif

  assign cand_ok  = in_grid && !edge_hit;
  assign tick_hit = one_sec && (per_q + PW'(1) == PER);

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    unique case (state_q)
      IDLE: begin
        if (one_sec) per_d = per_q + PW'(1);
        // A tick and a request in the same cycle start one attempt
        if (newRandom || tick_hit) begin
          per_d   = '0;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          cand_x_d = draw_x;
          cand_y_d = draw_y;
          state_d  = QUERY;
        end
      end
      QUERY: state_d = CHECK;
      CHECK: begin
        if (!bus.cell_rd_occ) begin
          rx_d    = cand_x_q;
          ry_d    = cand_y_q;
          state_d = EMIT;
        end else begin
          tries_d = tries_q + TW'(1);
          state_d = (tries_d == TMAX) ? IDLE : DRAW;
        end
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      per_q    <= '0;
      tries_q  <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      rx_q     <= 5'd4;
      ry_q     <= 4'd4;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      tries_q  <= tries_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
    end
  end

  assign bus.cell_rd_req = (state_q == QUERY);
  assign bus.cell_rd_x   = cand_x_q;
  assign bus.cell_rd_y   = cand_y_q;
  assign bus.randomRise  = (state_q == EMIT);
  assign bus.randomX     = rx_q;
  assign bus.randomY     = ry_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_random_cell_gen.sv
// Randomized bench for random_cell_gen against a cycle-schedule
// reference model driven by an independent LFSR copy.
module tb_random_cell_gen;
  import battle_pkg::*;

  localparam int SP = 3;
  localparam int MT = 8;
  localparam int C  = GRID_COLS;
  localparam int R  = GRID_ROWS;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic one_sec = 1'b0;
  logic newRandom = 1'b0;
  logic busy;

  random_cell_gen_if bus();

  random_cell_gen #(
    .COLS(C), .ROWS(R), .SPAWN_PERIOD(SP),
    .MAX_TRIES(MT), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .resetN(resetN), .one_sec(one_sec),
    .newRandom(newRandom), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  bit blk [C][R];
  logic [15:0] m;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic bit eligible(input logic [15:0] l);
    int x = int'(l[4:0]);
    int y = int'(l[11:8]);
    bit ok = (x < C) && (y < R);
`ifdef RANDOM_CELL_EXCLUDE_BORDER_EN
    ok = ok && x != 0 && x != C - 1 && y != 0 && y != R - 1;
`endif
    return ok;
  endfunction

  always @(posedge clk or negedge resetN)
    if (!resetN) m <= SEED;
    else         m <= nxt(m);

  always @(negedge clk) begin
    if (!resetN) bus.cell_rd_occ = 1'b0;
    else if (bus.cell_rd_req) begin
      if (int'(bus.cell_rd_x) < C && int'(bus.cell_rd_y) < R)
        bus.cell_rd_occ = blk[bus.cell_rd_x][bus.cell_rd_y];
      else
        bus.cell_rd_occ = 1'b1;
    end
  end

  task automatic set_map(input int mode);
    for (int x = 0; x < C; x++)
      for (int y = 0; y < R; y++)
        blk[x][y] = (mode == 1) ? 1'b1 :
                    (mode == 2) ? ($urandom_range(2) == 0) : 1'b0;
  endtask

  // Offsets count cycles from the first DRAW cycle (offset 0)
  task automatic predict(input logic [15:0] l0, input int free_nth,
                         output int rise_at, output int end_at,
                         output int reads, output int ex, output int ey);
    logic [15:0] l = l0;
    int off = 0;
    int tries = 0;
    int x, y;
    rise_at = -1; reads = 0; ex = 0; ey = 0;
    while (tries < MT && off < 5000) begin
      if (!eligible(l)) begin
        l = nxt(l); off++;
        continue;
      end
      reads++;
      x = int'(l[4:0]); y = int'(l[11:8]);
      if (reads == free_nth) blk[x][y] = 1'b0;
      if (!blk[x][y]) begin
        rise_at = off + 3; end_at = off + 4;
        ex = x; ey = y;
        return;
      end
      tries++;
      l = nxt(nxt(nxt(l))); off += 3;
    end
    end_at = off;
  endtask

  task automatic run_attempt(input bit tk, input bit nr, input bit inject,
                             input int free_nth, input string nm);
    int rise_at, end_at, reads, ex, ey;
    int seen = 0;
    one_sec = tk; newRandom = nr;
    @(negedge clk);
    one_sec = 1'b0; newRandom = 1'b0;
    predict(m, free_nth, rise_at, end_at, reads, ex, ey);
    for (int k = 0; k < end_at + 2; k++) begin
      vec++;
      if (bus.randomRise !== (k == rise_at)) begin
        bad++;
        $display("FAIL %s rise k=%0d got %b want %b",
                 nm, k, bus.randomRise, k == rise_at);
      end
      vec++;
      if (busy !== (k < end_at)) begin
        bad++;
        $display("FAIL %s busy k=%0d got %b want %b", nm, k, busy, k < end_at);
      end
      if (k == rise_at) begin
        vec++;
        if (int'(bus.randomX) != ex || int'(bus.randomY) != ey) begin
          bad++;
          $display("FAIL %s cell got (%0d,%0d) want (%0d,%0d)",
                   nm, bus.randomX, bus.randomY, ex, ey);
        end
      end
      if (bus.cell_rd_req === 1'b1) seen++;
      if (inject && k == 1) begin one_sec = 1'b1; newRandom = 1'b1; end
      @(negedge clk);
      one_sec = 1'b0; newRandom = 1'b0;
    end
    vec++;
    if (seen != reads) begin
      bad++;
      $display("FAIL %s reads got %0d want %0d", nm, seen, reads);
    end
  endtask

  task automatic tick_idle(input string nm);
    one_sec = 1'b1;
    @(negedge clk);
    one_sec = 1'b0;
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s early trigger busy got %b want 0", nm, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({bus.randomRise, bus.cell_rd_req, busy} !== 3'b000 ||
        bus.randomX !== 5'd4 || bus.randomY !== 4'd4 ||
        bus.cell_rd_x !== 5'd0 || bus.cell_rd_y !== 4'd0) begin
      bad++;
      $display("FAIL reset got rise=%b req=%b busy=%b X=%0d Y=%0d rx=%0d ry=%0d want 0 0 0 4 4 0 0",
               bus.randomRise, bus.cell_rd_req, busy, bus.randomX,
               bus.randomY, bus.cell_rd_x, bus.cell_rd_y);
    end
    resetN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spawn_timer();
    set_map(0);
    tick_idle("timer_t1");
    tick_idle("timer_t2");
    run_attempt(1'b1, 1'b0, 1'b0, 0, "timer");
  endtask

  task automatic test_new_random();
    set_map(0);
    tick_idle("newrnd_pre");
    run_attempt(1'b0, 1'b1, 1'b0, 0, "newrnd");
    tick_idle("newrnd_clr1");
    tick_idle("newrnd_clr2");
    run_attempt(1'b1, 1'b0, 1'b0, 0, "newrnd_auto");
  endtask

  task automatic test_all_blocked();
    set_map(1);
    run_attempt(1'b0, 1'b1, 1'b0, 0, "blocked");
  endtask

  task automatic test_single_free();
    set_map(1);
    run_attempt(1'b0, 1'b1, 1'b0, 3, "single_free");
  endtask

  task automatic test_back_to_back();
    set_map(0);
    tick_idle("coinc_t1");
    tick_idle("coinc_t2");
    run_attempt(1'b1, 1'b1, 1'b1, 0, "coincident");
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL queued_request busy got %b want 0", busy);
    end
    tick_idle("coinc_clr1");
    tick_idle("coinc_clr2");
    run_attempt(1'b1, 1'b0, 1'b0, 0, "coinc_auto");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_map(1);
    newRandom = 1'b1;
    @(negedge clk);
    newRandom = 1'b0;
    while (bus.cell_rd_req !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    vec++;
    if (n >= 300) begin
      bad++;
      $display("FAIL reset_mid no read strobe got timeout want req");
    end
    @(negedge clk);
    resetN = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b0 || bus.randomRise !== 1'b0 ||
        bus.randomX !== 5'd4 || bus.randomY !== 4'd4) begin
      bad++;
      $display("FAIL reset_mid got busy=%b rise=%b X=%0d Y=%0d want 0 0 4 4",
               busy, bus.randomRise, bus.randomX, bus.randomY);
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vec++;
      if (bus.randomRise !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_after k=%0d got rise=%b busy=%b want 0 0",
                 k, bus.randomRise, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      set_map(2);
      repeat ($urandom_range(5)) @(negedge clk);
      run_attempt(1'b0, 1'b1, 1'b0, 0, "random");
`ifdef RANDOM_CELL_EXCLUDE_BORDER_EN
      vec++;
      if (bus.randomX == 5'd0 || int'(bus.randomX) == C - 1 ||
          bus.randomY == 4'd0 || int'(bus.randomY) == R - 1) begin
        bad++;
        $display("FAIL border got (%0d,%0d) want interior",
                 bus.randomX, bus.randomY);
      end
`endif
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_spawn_timer();
    test_new_random();
    test_all_blocked();
    test_single_free();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
